// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the MIPS data-memory responder slice.
// The optional DMEM_MISALIGN_CHECK_EN feature is handled in dmem_responder.sv.
package mips_mem_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned DATA_W     = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Core-to-data-memory request/response bundle.
interface dmem_responder_if;
    import mips_mem_pkg::*;

    logic              mem_read;
    logic              mem_write;
    logic [31:0]       addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              ready;
    logic              busy;
    logic              misaligned;

    modport master (
        output mem_read, mem_write, addr, write_data,
        input  read_data, ready, busy, misaligned
    );

    modport slave (
        input  mem_read, mem_write, addr, write_data,
        output read_data, ready, busy, misaligned
    );

endinterface

// File: rtl/dmem_responder_array.sv
// Word-indexed single-port storage; read result is held in a resettable register.
module dmem_array
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           we,
    input  logic                           re,
    input  logic                           clr,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic [DATA_W-1:0]              wdata,
    output logic [DATA_W-1:0]              rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Storage contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (clr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits WAIT_CYCLES, pulses ready.
// Define DMEM_MISALIGN_CHECK_EN to flag and suppress accesses with addr[1:0] != 0.
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_responder_if.slave   bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

    dmem_state_t       state;
    dmem_state_t       state_nxt;
    logic [CNT_W-1:0]  cnt;

    logic              op_write;
    logic              op_mis;
    logic [IDX_W-1:0]  op_idx;
    logic [DATA_W-1:0] op_wdata;

    logic              req;
    logic              req_mis;
    logic [IDX_W-1:0]  req_idx;
    logic              cur_write;
    logic              cur_mis;
    logic [IDX_W-1:0]  cur_idx;
    logic [DATA_W-1:0] cur_wdata;
    logic              enter_resp;
    logic              unused_addr;

    assign req     = bus.mem_read | bus.mem_write;
    assign req_idx = bus.addr[IDX_W+1:2];

`ifdef DMEM_MISALIGN_CHECK_EN
    assign req_mis     = (bus.addr[1:0] != 2'b00);
    assign unused_addr = ^bus.addr[31:IDX_W+2];
`else
    assign req_mis     = 1'b0;
    assign unused_addr = ^{bus.addr[31:IDX_W+2], bus.addr[1:0]};
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT:    if (cnt == CNT_W'(1)) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            op_write <= 1'b0;
            op_mis   <= 1'b0;
            op_idx   <= '0;
            op_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req) begin
                cnt      <= CNT_W'(WAIT_CYCLES);
                op_write <= bus.mem_write;
                op_mis   <= req_mis;
                op_idx   <= req_idx;
                op_wdata <= bus.write_data;
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // With zero wait states RESP is entered on the accept edge, so the array
    // must see the live request rather than the latched copy.
    assign cur_write  = (state == IDLE) ? bus.mem_write  : op_write;
    assign cur_mis    = (state == IDLE) ? req_mis        : op_mis;
    assign cur_idx    = (state == IDLE) ? req_idx        : op_idx;
    assign cur_wdata  = (state == IDLE) ? bus.write_data : op_wdata;
    assign enter_resp = (state != RESP) && (state_nxt == RESP);

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (enter_resp &  cur_write & ~cur_mis),
        .re    (enter_resp & ~cur_write & ~cur_mis),
        .clr   (enter_resp & ~cur_write &  cur_mis),
        .idx   (cur_idx),
        .wdata (cur_wdata),
        .rdata (bus.read_data)
    );

    assign bus.ready      = (state == RESP);
    assign bus.busy       = (state != IDLE);
    assign bus.misaligned = (state == RESP) & op_mis;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances.
module tb_dmem_responder;
    import mips_mem_pkg::*;

`ifdef DMEM_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0]  lat;
        logic [31:0] rd;
        logic        mis;
        logic        busy_ok;
    } exp_t;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
    } op_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_responder_if bus_a ();
    dmem_responder_if bus_b ();

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;
    exp_t        sbq [$];
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic get_ready(bit w); return w ? bus_b.ready : bus_a.ready; endfunction
    function automatic logic get_busy(bit w);  return w ? bus_b.busy  : bus_a.busy;  endfunction
    function automatic logic get_mis(bit w);   return w ? bus_b.misaligned : bus_a.misaligned; endfunction
    function automatic logic [31:0] get_rdata(bit w); return w ? bus_b.read_data : bus_a.read_data; endfunction

    task automatic drive(input bit w, input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        if (w) begin
            bus_b.mem_read = rd; bus_b.mem_write = wr; bus_b.addr = a; bus_b.write_data = d;
        end else begin
            bus_a.mem_read = rd; bus_a.mem_write = wr; bus_a.addr = a; bus_a.write_data = d;
        end
    endtask

    // Reference model: word memory, wrap on addr[9:2], store wins over load.
    function automatic exp_t predict(bit w, op_t op);
        exp_t       e;
        logic [7:0] idx = op.a[9:2];
        bit         mis = MIS_EN && (op.a[1:0] != 2'b00);
        e.lat     = w ? 8'd1 : 8'd3;
        e.mis     = mis;
        e.busy_ok = 1'b1;
        if (op.wr) begin
            if (!mis) begin
                if (w) mem_b[idx] = op.d; else mem_a[idx] = op.d;
            end
            e.rd = w ? last_b : last_a;
        end else begin
            e.rd = mis ? 32'h0 : (w ? mem_b[idx] : mem_a[idx]);
            if (w) last_b = e.rd; else last_a = e.rd;
        end
        return e;
    endfunction

    // One request held for a single accept edge; measures latency and busy profile.
    task automatic access(input bit w, input op_t op, output exp_t obs);
        int lat;
        bit bok;
        @(negedge clk);
        drive(w, op.rd, op.wr, op.a, op.d);
        @(posedge clk);
        @(negedge clk);
        drive(w, 1'b0, 1'b0, op.a, op.d);
        lat = 1;
        bok = get_busy(w);
        while (!get_ready(w) && lat < 20) begin
            @(negedge clk);
            lat++;
            bok = bok & get_busy(w);
        end
        obs.lat = 8'(lat);
        obs.rd  = get_rdata(w);
        obs.mis = get_mis(w);
        @(negedge clk);
        bok = bok & !get_busy(w) & !get_ready(w);
        obs.busy_ok = bok;
    endtask

    task automatic test_reset();
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus_a.read_data, bus_a.ready, bus_a.busy, bus_a.misaligned} !== 35'h0) begin
            miscompares++;
            $display("FAIL reset_a got rd=%h rdy=%b busy=%b mis=%b expected all zero",
                     bus_a.read_data, bus_a.ready, bus_a.busy, bus_a.misaligned);
        end
        vectors++;
        if ({bus_b.read_data, bus_b.ready, bus_b.busy, bus_b.misaligned} !== 35'h0) begin
            miscompares++;
            $display("FAIL reset_b got rd=%h rdy=%b busy=%b mis=%b expected all zero",
                     bus_b.read_data, bus_b.ready, bus_b.busy, bus_b.misaligned);
        end
    endtask

    task automatic test_store_load();
        op_t  ops [2] = '{'{1'b0, 1'b1, 32'h10, 32'hDEADBEEF}, '{1'b1, 1'b0, 32'h10, 32'h0}};
        exp_t obs, e;
        foreach (ops[i]) begin
            sbq.push_back(predict(0, ops[i]));
            access(0, ops[i], obs);
            e = sbq.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL store_load[%0d] got lat=%0d rd=%h mis=%b busy_ok=%b, expected lat=%0d rd=%h mis=%b busy_ok=%b",
                         i, obs.lat, obs.rd, obs.mis, obs.busy_ok, e.lat, e.rd, e.mis, e.busy_ok);
            end
        end
    endtask

    task automatic test_wrap();
        op_t  ops [3] = '{'{1'b0, 1'b1, 32'h0,   32'h11111111},
                          '{1'b0, 1'b1, 32'h400, 32'h22222222},
                          '{1'b1, 1'b0, 32'h0,   32'h0}};
        exp_t obs, e;
        foreach (ops[i]) begin
            sbq.push_back(predict(0, ops[i]));
            access(0, ops[i], obs);
            e = sbq.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL wrap[%0d] got lat=%0d rd=%h mis=%b busy_ok=%b, expected lat=%0d rd=%h mis=%b busy_ok=%b",
                         i, obs.lat, obs.rd, obs.mis, obs.busy_ok, e.lat, e.rd, e.mis, e.busy_ok);
            end
        end
    endtask

    task automatic test_both_high();
        op_t  ops [2] = '{'{1'b1, 1'b1, 32'h8, 32'hA5A5A5A5}, '{1'b1, 1'b0, 32'h8, 32'h0}};
        exp_t obs, e;
        foreach (ops[i]) begin
            sbq.push_back(predict(0, ops[i]));
            access(0, ops[i], obs);
            e = sbq.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL both_high[%0d] got lat=%0d rd=%h mis=%b busy_ok=%b, expected lat=%0d rd=%h mis=%b busy_ok=%b",
                         i, obs.lat, obs.rd, obs.mis, obs.busy_ok, e.lat, e.rd, e.mis, e.busy_ok);
            end
        end
    endtask

    task automatic test_back_to_back();
        op_t          st = '{1'b0, 1'b1, 32'h10, 32'hCAFEF00D};
        exp_t         obs, e;
        logic [32:0]  q [$];
        logic [32:0]  got, want;
        sbq.push_back(predict(1, st));
        access(1, st, obs);
        e = sbq.pop_front();
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL b2b_store got lat=%0d rd=%h mis=%b busy_ok=%b, expected lat=%0d rd=%h mis=%b busy_ok=%b",
                     obs.lat, obs.rd, obs.mis, obs.busy_ok, e.lat, e.rd, e.mis, e.busy_ok);
        end
        // mem_read held for 8 edges: accept, RESP, accept, RESP, ...
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 32'h10, '0);
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                q.push_back({1'b1, mem_b[4]});
                last_b = mem_b[4];
            end else begin
                q.push_back({1'b0, 32'h0});
            end
            @(posedge clk);
            @(negedge clk);
            if (i == 7) drive(1, 1'b0, 1'b0, 32'h10, '0);
            got  = {bus_b.ready, bus_b.ready ? bus_b.read_data : 32'h0};
            want = q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL b2b_cycle[%0d] got ready=%b rd=%h, expected ready=%b rd=%h",
                         i, got[32], got[31:0], want[32], want[31:0]);
            end
        end
    endtask

    task automatic test_reset_abort();
        op_t  pre  = '{1'b0, 1'b1, 32'h20, 32'h12345678};
        op_t  ld   = '{1'b1, 1'b0, 32'h20, 32'h0};
        exp_t obs, e;
        int   rdy_seen = 0;
        sbq.push_back(predict(0, pre));
        access(0, pre, obs);
        e = sbq.pop_front();
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL abort_prestore got lat=%0d rd=%h busy_ok=%b, expected lat=%0d rd=%h busy_ok=%b",
                     obs.lat, obs.rd, obs.busy_ok, e.lat, e.rd, e.busy_ok);
        end
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 32'h20, 32'h55);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h20, 32'h55);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus_a.read_data, bus_a.ready, bus_a.busy, bus_a.misaligned} !== 35'h0) begin
            miscompares++;
            $display("FAIL abort_outputs got rd=%h rdy=%b busy=%b mis=%b expected all zero",
                     bus_a.read_data, bus_a.ready, bus_a.busy, bus_a.misaligned);
        end
        last_a = '0;
        last_b = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus_a.ready) rdy_seen++;
        end
        vectors++;
        if (rdy_seen !== 0) begin
            miscompares++;
            $display("FAIL abort_no_ready got %0d ready pulses, expected 0", rdy_seen);
        end
        sbq.push_back(predict(0, ld));
        access(0, ld, obs);
        e = sbq.pop_front();
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL abort_reload got lat=%0d rd=%h busy_ok=%b, expected lat=%0d rd=%h busy_ok=%b",
                     obs.lat, obs.rd, obs.busy_ok, e.lat, e.rd, e.busy_ok);
        end
    endtask

    task automatic test_misalign();
        op_t  ops [3] = '{'{1'b0, 1'b1, 32'h22, 32'h99999999},
                          '{1'b1, 1'b0, 32'h20, 32'h0},
                          '{1'b1, 1'b0, 32'h21, 32'h0}};
        exp_t obs, e;
        foreach (ops[i]) begin
            sbq.push_back(predict(0, ops[i]));
            access(0, ops[i], obs);
            e = sbq.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL misalign[%0d] got lat=%0d rd=%h mis=%b busy_ok=%b, expected lat=%0d rd=%h mis=%b busy_ok=%b",
                         i, obs.lat, obs.rd, obs.mis, obs.busy_ok, e.lat, e.rd, e.mis, e.busy_ok);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_wrap();
        test_both_high();
        test_back_to_back();
        test_reset_abort();
        test_misalign();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
